// File: rtl/hex_line_rx_pkg.sv
// Shared types and constants for the serial hex-line receiver.
// Holds the receiver/parser state encodings, error codes and ASCII constants.
// Also provides the ASCII-hex digit decoder used by the line parser.
package hex_line_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ACC,
    P_DISCARD
  } parse_state_t;

  typedef enum logic [1:0] {
    E_NONE     = 2'd0,
    E_FRAME    = 2'd1,
    E_BADCHAR  = 2'd2,
    E_OVERFLOW = 2'd3
  } err_code_t;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  // Returns {is_hex, nibble}; nibble is zero when the byte is not a hex digit.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [7:0] d;
    d = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      d = c - 8'h30;
      return {1'b1, d[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      d = c - 8'h37;
      return {1'b1, d[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      d = c - 8'h57;
      return {1'b1, d[3:0]};
    end
    return 5'd0;
  endfunction

endpackage

// File: rtl/hex_line_rx_uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF input synchronizer and false-start rejection.
// Latency: byte_stb/frame_err are combinational in the stop-bit sample cycle.
// Backpressure: none; every received byte is strobed once and must be consumed.
module uart_rx_byte
  import hex_line_rx_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk_50MHz,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          hold, hold_nxt;
  logic          rx_s1, rx_s2, rx_d;

  // Synchronize the asynchronous line and keep one delayed copy for edge detection.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver state register; a reset drops any partially received byte.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      hold    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
      hold    <= hold_nxt;
    end
  end

  // Next-state logic: mid-bit sampling; after a bad stop bit, park in STOP until the line is high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    hold_nxt  = hold;
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_d && !rx_s2) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_nxt = '0;
          bit_nxt = 3'd0;
          state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s2, shreg[7:1]};
          bit_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (hold) begin
          cnt_nxt = '0;
          if (rx_s2) begin
            hold_nxt  = 1'b0;
            state_nxt = RX_IDLE;
          end
        end else if (cnt == LAST) begin
          cnt_nxt = '0;
          if (rx_s2) begin
            byte_stb  = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            frame_err = 1'b1;
            hold_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = shreg;
  assign rx_busy = (state != RX_IDLE);

endmodule

// File: rtl/hex_line_rx.sv
// UART receiver plus ASCII-hex line parser producing a binary value per text line.
// Latency: valid/err rise 1 clk after the stop-bit sample of the deciding byte.
// Backpressure: none; valid and err are single-cycle pulses, value/err_code hold.
module hex_line_rx
  import hex_line_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int MAX_DIGITS = 8
) (
  input  logic                    clk_50MHz,
  input  logic                    reset_n,
  input  logic                    uart_rx,
  output logic [4*MAX_DIGITS-1:0] value,
  output logic [3:0]              ndigits,
  output logic                    valid,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int W   = 4 * MAX_DIGITS;
  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  logic [7:0] rx_byte;
  logic       byte_stb, frame_err, rx_busy;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .rx_byte   (rx_byte),
    .byte_stb  (byte_stb),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  parse_state_t p_state, p_nxt;
  logic [W-1:0] acc, acc_nxt, value_nxt;
  logic [3:0]   dcnt, dcnt_nxt, nd_nxt;
  logic         valid_nxt, err_nxt;
  err_code_t    code_q, code_nxt;
  logic [4:0]   hexd;
  logic         is_term;

  assign hexd    = hex_nib(rx_byte);
  assign is_term = (rx_byte == CH_CR) || (rx_byte == CH_LF);

  // Parser state and registered outputs; a reset discards any partial line.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      p_state <= P_IDLE;
      acc     <= '0;
      dcnt    <= 4'd0;
      value   <= '0;
      ndigits <= 4'd0;
      valid   <= 1'b0;
      err     <= 1'b0;
      code_q  <= E_NONE;
    end else begin
      p_state <= p_nxt;
      acc     <= acc_nxt;
      dcnt    <= dcnt_nxt;
      value   <= value_nxt;
      ndigits <= nd_nxt;
      valid   <= valid_nxt;
      err     <= err_nxt;
      code_q  <= code_nxt;
    end
  end

  // Per-byte parsing: accumulate digits, publish on terminator, discard the rest of a bad line.
  always_comb begin
    p_nxt     = p_state;
    acc_nxt   = acc;
    dcnt_nxt  = dcnt;
    value_nxt = value;
    nd_nxt    = ndigits;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = code_q;
    if (frame_err) begin
      err_nxt  = 1'b1;
      code_nxt = E_FRAME;
      p_nxt    = P_DISCARD;
    end else if (byte_stb && rx_byte != CH_SP) begin
      if (p_state == P_DISCARD) begin
        if (is_term) begin
          p_nxt    = P_IDLE;
          acc_nxt  = '0;
          dcnt_nxt = 4'd0;
        end
      end else if (is_term) begin
        // A terminator with no digits (blank line, second half of CR LF) is silent.
        if (p_state == P_ACC) begin
          valid_nxt = 1'b1;
          value_nxt = acc;
          nd_nxt    = dcnt;
        end
        p_nxt    = P_IDLE;
        acc_nxt  = '0;
        dcnt_nxt = 4'd0;
      end else if (hexd[4]) begin
        if (dcnt == MAXD) begin
          err_nxt  = 1'b1;
          code_nxt = E_OVERFLOW;
          p_nxt    = P_DISCARD;
        end else begin
          acc_nxt  = {acc[W-5:0], hexd[3:0]};
          dcnt_nxt = dcnt + 4'd1;
          p_nxt    = P_ACC;
        end
      end else begin
        err_nxt  = 1'b1;
        code_nxt = E_BADCHAR;
        p_nxt    = P_DISCARD;
      end
    end
  end

  assign err_code = code_q;
  assign busy     = rx_busy | (p_state != P_IDLE);

endmodule

// File: tb/tb_hex_line_rx.sv
// Directed bench for hex_line_rx: serial lines in, parsed value / error pulses checked.
// Runs at a faster baud (DIV=100) to keep the run short; glitch scaled below half a bit.
// Valid/err pulses are counted by a monitor and compared against hand-computed results.
module tb_hex_line_rx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 500_000;
  localparam int DIV    = 100;

  logic        clk_50MHz = 1'b0;
  logic        reset_n   = 1'b0;
  logic        uart_rx   = 1'b1;
  logic [31:0] value;
  logic [3:0]  ndigits;
  logic        valid, err, busy;
  logic [1:0]  err_code;

  hex_line_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_DIGITS(8)) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .value     (value),
    .ndigits   (ndigits),
    .valid     (valid),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int total = 0;
  int bad   = 0;
  int n_valid = 0, n_err = 0, n_both = 0;
  logic [1:0] last_code = 2'd0;

  always @(negedge clk_50MHz) begin
    if (valid) n_valid++;
    if (err) begin
      n_err++;
      last_code = err_code;
    end
    if (valid && err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_50MHz);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk_50MHz);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk_50MHz);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(negedge clk_50MHz);
    uart_rx = 1'b1;
    repeat (DIV / 2) @(negedge clk_50MHz);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    repeat (DIV) @(negedge clk_50MHz);
  endtask

  int v0, e0;

  initial begin
    logic [7:0] b;
    repeat (5) @(negedge clk_50MHz);
    check("rst_value", value, 32'h0);
    check("rst_ndigits", {28'd0, ndigits}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_50MHz);

    // 1: basic line
    v0 = n_valid; e0 = n_err;
    send_str("1A");
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    send_str("3F\r");
    check("t1_nvalid", n_valid - v0, 1);
    check("t1_value", value, 32'h00001A3F);
    check("t1_ndigits", {28'd0, ndigits}, 32'd4);
    check("t1_nerr", n_err - e0, 0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: full width, lower case, LF terminator; then blank CR LF
    v0 = n_valid;
    send_str("deadbeef\n");
    check("t2_nvalid", n_valid - v0, 1);
    check("t2_value", value, 32'hDEADBEEF);
    check("t2_ndigits", {28'd0, ndigits}, 32'd8);
    v0 = n_valid;
    send_str("\r\n");
    check("t2_crlf_nvalid", n_valid - v0, 0);

    // 3: overflow on the ninth digit
    v0 = n_valid; e0 = n_err;
    send_str("123456789\r");
    check("t3_nerr", n_err - e0, 1);
    check("t3_code", {30'd0, last_code}, 32'd3);
    check("t3_err_code_hold", {30'd0, err_code}, 32'd3);
    check("t3_nvalid", n_valid - v0, 0);
    check("t3_value_kept", value, 32'hDEADBEEF);

    // 4: bad character, then recovery
    v0 = n_valid; e0 = n_err;
    send_str("12G4\r");
    check("t4_nerr", n_err - e0, 1);
    check("t4_code", {30'd0, last_code}, 32'd2);
    check("t4_nvalid", n_valid - v0, 0);
    v0 = n_valid;
    send_str("7\r");
    check("t4b_nvalid", n_valid - v0, 1);
    check("t4b_value", value, 32'h7);
    check("t4b_ndigits", {28'd0, ndigits}, 32'd1);

    // 5: framing error discards the rest of that line
    e0 = n_err;
    send_byte(8'h41, 1'b0);
    repeat (DIV) @(negedge clk_50MHz);
    check("t5_nerr", n_err - e0, 1);
    check("t5_code", {30'd0, last_code}, 32'd1);
    v0 = n_valid;
    send_str("5\r");
    check("t5_discard_nvalid", n_valid - v0, 0);
    check("t5_discard_value", value, 32'h7);
    send_str("5\r");
    check("t5_nvalid", n_valid - v0, 1);
    check("t5_value", value, 32'h5);

    // 6a: low glitch shorter than half a bit is a false start
    v0 = n_valid; e0 = n_err;
    @(negedge clk_50MHz);
    uart_rx = 1'b0;
    repeat (DIV * 2 / 5) @(negedge clk_50MHz);
    uart_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk_50MHz);
    check("t6_glitch_nerr", n_err - e0, 0);
    check("t6_glitch_nvalid", n_valid - v0, 0);
    check("t6_glitch_busy", {31'd0, busy}, 32'd0);

    // 6b: reset in the middle of "AB", then CR
    v0 = n_valid;
    send_byte(8'h41, 1'b1);
    b = 8'h42;
    @(negedge clk_50MHz);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk_50MHz);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) reset_n = 1'b0;
      uart_rx = b[i];
      repeat (DIV) @(negedge clk_50MHz);
    end
    uart_rx = 1'b1;
    repeat (DIV) @(negedge clk_50MHz);
    check("t6_rst_valid", {31'd0, valid}, 32'd0);
    check("t6_rst_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_50MHz);
    check("t6_rst_value", value, 32'h0);
    check("t6_rst_ndigits", {28'd0, ndigits}, 32'd0);
    check("t6_rst_err_code", {30'd0, err_code}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    send_str("\r");
    check("t6_cr_nvalid", n_valid - v0, 0);
    check("t6_cr_value", value, 32'h0);

    check("never_valid_and_err", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
